// File: rtl/xadc_mux_sequencer_pkg.sv
// Shared constants for the XADC external-mux sequencer.
// Covers the FSM state encoding, the default DRP result address and the result and mux widths.
package xadc_mux_sequencer_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_SELECT    = 4'd1;
  localparam logic [3:0] ST_SETTLE    = 4'd2;
  localparam logic [3:0] ST_CONVERT   = 4'd3;
  localparam logic [3:0] ST_WAIT_EOC  = 4'd4;
  localparam logic [3:0] ST_READ      = 4'd5;
  localparam logic [3:0] ST_WAIT_DRDY = 4'd6;
  localparam logic [3:0] ST_STORE     = 4'd7;
  localparam logic [3:0] ST_NEXT      = 4'd8;

  localparam logic [6:0] DRP_RESULT_ADDR_DEF = 7'h03;
  localparam int         RESULT_W            = 12;
  localparam int         MUX_W               = 4;

endpackage

// File: rtl/xadc_next_ch.sv
// Combinational priority finder: lowest set mask bit strictly above cur_i.
// When wrap_i is set, it finds the lowest set bit overall.
module xadc_next_ch
  import xadc_mux_sequencer_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int CH_W   = MUX_W
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [CH_W-1:0]   cur_i,
  input  logic              wrap_i,
  output logic [CH_W-1:0]   nxt_o,
  output logic              found_o
);

  // Scanning downwards lets the lowest qualifying bit win.
  always_comb begin
    nxt_o   = '0;
    found_o = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (wrap_i || (i > int'(cur_i)))) begin
        nxt_o   = CH_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xadc_mux_sequencer.sv
// Sweeps the external analog mux over a channel mask: select, settle, convert, DRP read, post result.
// One FSM; the sweep mask is latched per sweep so live mask edits apply to the next sweep only.
module xadc_mux_sequencer
  import xadc_mux_sequencer_pkg::*;
#(
  parameter int         NUM_CH          = 16,
  parameter int         TIMEOUT_CYCLES  = 4096,
  parameter logic [6:0] DRP_RESULT_ADDR = DRP_RESULT_ADDR_DEF,
  localparam int        CH_W            = $clog2(NUM_CH)
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  input  logic                enable,
  input  logic                start,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [15:0]         settle_cycles,
  output logic [CH_W-1:0]     XADC_MUXADDR,
  output logic                conv_start,
  input  logic                eoc,
  output logic                drp_den,
  output logic [6:0]          drp_daddr,
  input  logic                drp_drdy,
  input  logic [15:0]         drp_do,
  output logic                result_valid,
  output logic [CH_W-1:0]     result_ch,
  output logic [RESULT_W-1:0] result_data,
  output logic                sweep_done,
  output logic                busy,
  output logic                err_timeout
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [3:0]          state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic                oneshot_q, oneshot_d;
  logic [15:0]         settle_q, settle_d;
  logic [TO_W-1:0]     tcnt_q, tcnt_d;
  logic                err_q, err_d;
  logic                res_vld_q, res_vld_d;
  logic [CH_W-1:0]     res_ch_q, res_ch_d;
  logic [RESULT_W-1:0] res_data_q, res_data_d;
  logic                done_c;

  logic [CH_W-1:0]     live_ch, sweep_ch;
  logic                live_found, sweep_found;
  logic                unused_drp_lsb;

  assign unused_drp_lsb = ^drp_do[3:0];

  xadc_next_ch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_live (
    .mask_i (ch_mask),
    .cur_i  ('0),
    .wrap_i (1'b1),
    .nxt_o  (live_ch),
    .found_o(live_found)
  );

  xadc_next_ch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_sweep (
    .mask_i (mask_q),
    .cur_i  (ch_q),
    .wrap_i (1'b0),
    .nxt_o  (sweep_ch),
    .found_o(sweep_found)
  );

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    mask_d     = mask_q;
    oneshot_d  = oneshot_q;
    settle_d   = settle_q;
    tcnt_d     = tcnt_q;
    err_d      = err_q;
    res_vld_d  = 1'b0;
    res_ch_d   = res_ch_q;
    res_data_d = res_data_q;
    done_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) err_d = 1'b0;
        if ((start || enable) && live_found) begin
          mask_d    = ch_mask;
          ch_d      = live_ch;
          oneshot_d = start;
          state_d   = ST_SELECT;
        end
      end
      ST_SELECT: begin
        settle_d = settle_cycles;
        state_d  = (settle_cycles == 16'd0) ? ST_CONVERT : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q <= 16'd1) state_d = ST_CONVERT;
        else                   settle_d = settle_q - 16'd1;
      end
      ST_CONVERT: begin
        tcnt_d  = '0;
        state_d = ST_WAIT_EOC;
      end
      ST_WAIT_EOC: begin
        if (eoc) begin
          state_d = ST_READ;
        end else if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = ST_NEXT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_READ: begin
        tcnt_d  = '0;
        state_d = ST_WAIT_DRDY;
      end
      ST_WAIT_DRDY: begin
        if (drp_drdy) begin
          res_vld_d  = 1'b1;
          res_ch_d   = ch_q;
          res_data_d = drp_do[15:4];
          state_d    = ST_STORE;
        end else if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = ST_NEXT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_STORE: state_d = ST_NEXT;
      ST_NEXT: begin
        // A single-shot sweep keeps going after enable drops; a continuous one stops here.
        if (sweep_found) begin
          if (enable || oneshot_q) begin
            ch_d    = sweep_ch;
            state_d = ST_SELECT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          done_c = 1'b1;
          if (enable && live_found) begin
            mask_d    = ch_mask;
            ch_d      = live_ch;
            oneshot_d = 1'b0;
            state_d   = ST_SELECT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      mask_q     <= '0;
      oneshot_q  <= 1'b0;
      settle_q   <= '0;
      tcnt_q     <= '0;
      err_q      <= 1'b0;
      res_vld_q  <= 1'b0;
      res_ch_q   <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      mask_q     <= mask_d;
      oneshot_q  <= oneshot_d;
      settle_q   <= settle_d;
      tcnt_q     <= tcnt_d;
      err_q      <= err_d;
      res_vld_q  <= res_vld_d;
      res_ch_q   <= res_ch_d;
      res_data_q <= res_data_d;
    end
  end

  assign XADC_MUXADDR = ch_q;
  assign conv_start   = (state_q == ST_CONVERT);
  assign drp_den      = (state_q == ST_READ);
  assign drp_daddr    = DRP_RESULT_ADDR;
  assign result_valid = res_vld_q;
  assign result_ch    = res_ch_q;
  assign result_data  = res_data_q;
  assign sweep_done   = done_c;
  assign busy         = (state_q != ST_IDLE);
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_xadc_mux_sequencer.sv
// Directed bench for xadc_mux_sequencer with an XADC/DRP responder model and a result scoreboard.
module tb_xadc_mux_sequencer;

  typedef struct {
    logic [3:0]  ch;
    logic [11:0] data;
  } res_t;

  logic        clk, rst_n, enable, start;
  logic [15:0] ch_mask, settle_cycles;
  logic [3:0]  mux;
  logic        conv_start, eoc, drp_den, drp_drdy;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_do;
  logic        result_valid, sweep_done, busy, err_timeout;
  logic [3:0]  result_ch;
  logic [11:0] result_data;

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   eoc_delay = 10;
  int   drdy_delay = 2;
  logic eoc_en = 1'b1;

  logic [15:0] drp_tbl [16];
  res_t        exp_res [$];
  logic [3:0]  exp_mux [$];

  xadc_mux_sequencer #(
    .NUM_CH(16), .TIMEOUT_CYCLES(32), .DRP_RESULT_ADDR(7'h03)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .enable       (enable),
    .start        (start),
    .ch_mask      (ch_mask),
    .settle_cycles(settle_cycles),
    .XADC_MUXADDR (mux),
    .conv_start   (conv_start),
    .eoc          (eoc),
    .drp_den      (drp_den),
    .drp_daddr    (drp_daddr),
    .drp_drdy     (drp_drdy),
    .drp_do       (drp_do),
    .result_valid (result_valid),
    .result_ch    (result_ch),
    .result_data  (result_data),
    .sweep_done   (sweep_done),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // XADC/DRP model: eoc eoc_delay cycles after conv_start, drdy drdy_delay cycles after den.
  initial begin
    int ecnt, dcnt;
    logic [3:0] dch;
    ecnt = 0; dcnt = 0; dch = 4'd0;
    eoc = 1'b0; drp_drdy = 1'b0; drp_do = 16'h0000;
    forever begin
      @(negedge clk);
      eoc      = (ecnt == 1);
      drp_drdy = (dcnt == 1);
      if (dcnt == 1) drp_do = drp_tbl[dch];
      if (ecnt > 0) ecnt--;
      if (dcnt > 0) dcnt--;
      if (conv_start && eoc_en) ecnt = eoc_delay;
      if (drp_den) begin
        dcnt = drdy_delay;
        dch  = mux;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    res_t       r;
    logic [3:0] m;
    forever begin
      @(negedge clk);
      if (conv_start) begin
        if (exp_mux.size() == 0) begin
          total++; bad++;
          $display("FAIL mux_order: unexpected conv_start on ch %0d", mux);
        end else begin
          m = exp_mux.pop_front();
          chk("mux_order", 32'(mux), 32'(m));
        end
      end
      if (result_valid) begin
        if (exp_res.size() == 0) begin
          total++; bad++;
          $display("FAIL result: unexpected result ch=%0d data=%0h", result_ch, result_data);
        end else begin
          r = exp_res.pop_front();
          chk("result_ch", 32'(result_ch), 32'(r.ch));
          chk("result_data", 32'(result_data), 32'(r.data));
        end
      end
      if (sweep_done) done_cnt++;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    if (busy) begin
      total++; bad++;
      $display("FAIL %s: busy still 1 after %0d cycles, required 0", nm, budget);
    end
  endtask

  task automatic push_res(input logic [3:0] ch, input logic [11:0] d);
    res_t r;
    r.ch = ch; r.data = d;
    exp_res.push_back(r);
  endtask

  initial begin
    int n, d;
    drp_tbl = '{default: 16'h0000};
    drp_tbl[0]  = 16'h1230;
    drp_tbl[2]  = 16'h4560;
    drp_tbl[3]  = 16'h7890;
    drp_tbl[4]  = 16'hABC0;
    drp_tbl[15] = 16'hFED7;
    rst_n = 1'b0; enable = 1'b0; start = 1'b0;
    ch_mask = 16'h0000; settle_cycles = 16'd0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mux", 32'(mux), 0);
    chk("rst_daddr", 32'(drp_daddr), 32'h3);
    chk("rst_conv", 32'(conv_start), 0);
    chk("rst_den", 32'(drp_den), 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_done", 32'(sweep_done), 0);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_data", 32'(result_data), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single sweep over ch0, ch2 with settle 4.
    done_cnt = 0; ch_mask = 16'h0005; settle_cycles = 16'd4;
    exp_mux.push_back(4'd0); exp_mux.push_back(4'd2);
    push_res(4'd0, 12'h123); push_res(4'd2, 12'h456);
    pulse_start();
    n = 0;
    do begin @(negedge clk); n++; end while (!result_valid && n < 100);
    chk("t1_first_result_latency", 32'(n), 32'd20);
    wait_idle("t1_idle", 200);
    chk("t1_sweep_done", 32'(done_cnt), 1);
    chk("t1_busy", 32'(busy), 0);

    // Continuous sweeping over ch0/ch15 for three sweeps.
    done_cnt = 0; ch_mask = 16'h8001; settle_cycles = 16'd2;
    for (int k = 0; k < 3; k++) begin
      exp_mux.push_back(4'd0); exp_mux.push_back(4'd15);
      push_res(4'd0, 12'h123); push_res(4'd15, 12'hFED);
    end
    @(posedge clk); #1 enable = 1'b1;
    d = 0; n = 0;
    while (d < 3 && n < 1000) begin
      @(negedge clk); n++;
      if (sweep_done) begin
        d++;
        if (d == 3) enable = 1'b0;
      end
    end
    chk("t2_sweeps_seen", 32'(d), 3);
    wait_idle("t2_idle", 200);
    chk("t2_done_pulses", 32'(done_cnt), 3);

    // Zero settle: conv_start two cycles after start is accepted.
    done_cnt = 0; ch_mask = 16'h0010; settle_cycles = 16'd0;
    exp_mux.push_back(4'd4); push_res(4'd4, 12'hABC);
    pulse_start();
    n = 0;
    do begin @(negedge clk); n++; end while (!conv_start && n < 50);
    chk("t3_conv_latency", 32'(n), 2);
    wait_idle("t3_idle", 200);
    chk("t3_done", 32'(done_cnt), 1);

    // eoc never arrives: both channels time out, no results.
    done_cnt = 0; eoc_en = 1'b0; ch_mask = 16'h0003; settle_cycles = 16'd1;
    exp_mux.push_back(4'd0); exp_mux.push_back(4'd1);
    pulse_start();
    n = 0;
    do begin @(negedge clk); n++; end while (!conv_start && n < 50);
    n = 0;
    do begin @(negedge clk); n++; end while (!err_timeout && n < 100);
    chk("t4_err_latency", 32'(n), 33);
    wait_idle("t4_idle", 300);
    chk("t4_err_sticky", 32'(err_timeout), 1);
    chk("t4_done", 32'(done_cnt), 1);
    eoc_en = 1'b1;
    ch_mask = 16'h0010;
    exp_mux.push_back(4'd4); push_res(4'd4, 12'hABC);
    pulse_start();
    @(negedge clk);
    chk("t4_err_cleared", 32'(err_timeout), 0);
    wait_idle("t4b_idle", 200);

    // Empty mask: start and enable both leave the block idle.
    done_cnt = 0; ch_mask = 16'h0000;
    pulse_start();
    repeat (4) @(negedge clk);
    chk("t5_start_mask0_busy", 32'(busy), 0);
    @(posedge clk); #1 enable = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5_enable_mask0_busy", 32'(busy), 0);
    enable = 1'b0;
    chk("t5_no_done", 32'(done_cnt), 0);

    // Mask edited mid-sweep only affects the next sweep.
    ch_mask = 16'h0005; settle_cycles = 16'd1;
    exp_mux.push_back(4'd0); exp_mux.push_back(4'd2);
    push_res(4'd0, 12'h123); push_res(4'd2, 12'h456);
    pulse_start();
    n = 0;
    do begin @(negedge clk); n++; end while (!conv_start && n < 50);
    ch_mask = 16'h0008;
    wait_idle("t5_mid_idle", 200);
    exp_mux.push_back(4'd3); push_res(4'd3, 12'h789);
    pulse_start();
    wait_idle("t5_next_idle", 200);
    chk("t5_done", 32'(done_cnt), 2);

    // Reset during WAIT_DRDY; the late drdy must be ignored.
    ch_mask = 16'h0004; drdy_delay = 8;
    exp_mux.push_back(4'd2);
    pulse_start();
    n = 0;
    do begin @(negedge clk); n++; end while (!drp_den && n < 100);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_mux", 32'(mux), 0);
    chk("t6_rst_result_data", 32'(result_data), 0);
    chk("t6_rst_result_ch", 32'(result_ch), 0);
    chk("t6_rst_valid", 32'(result_valid), 0);
    chk("t6_rst_den", 32'(drp_den), 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t6_after_busy", 32'(busy), 0);

    chk("exp_mux_drained", 32'(exp_mux.size()), 0);
    chk("exp_res_drained", 32'(exp_res.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
